// File: rtl/memwrite_checker.sv
// Snoops a data-memory write port and checks it against a programmed sequence of
// expected (address, data) writes, reporting pass, mismatch, timeout or empty table.
module memwrite_checker #(
    parameter int DEPTH      = 8,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 1000,
    parameter int IGNORE_EN  = 1,
    parameter logic [AW-1:0] IGNORE_ADR = AW'(80),
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_adr,
    input  logic [DW-1:0] cfg_data,
    input  logic [CW-1:0] cfg_count,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [IW-1:0] fail_idx,
    output logic [AW-1:0] fail_adr,
    output logic [DW-1:0] fail_data
);
    // state | meaning
    // IDLE  | waiting for start, table writable
    // RUN   | snooping writes, cycle counter running
    // PASS  | all expected writes seen in order
    // FAIL  | mismatch, timeout or empty table
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CODE_EMPTY    = 2'd3;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [TW-1:0] cyc, cyc_nxt;
    logic          busy_nxt, pass_nxt, fail_nxt;
    logic [1:0]    code_nxt;
    logic [IW-1:0] fidx_nxt;
    logic [AW-1:0] fadr_nxt;
    logic [DW-1:0] fdata_nxt;
    logic          hit, last, ignorable;

    logic [AW-1:0] exp_adr  [DEPTH];
    logic [DW-1:0] exp_data [DEPTH];

    always_ff @(posedge clk) begin
        if (cfg_we && state != RUN) begin
            exp_adr[cfg_idx]  <= cfg_adr;
            exp_data[cfg_idx] <= cfg_data;
        end
    end

    assign hit       = (exp_adr[ptr] == dataadr) && (exp_data[ptr] == writedata);
    assign last      = (CW'(ptr) == count - CW'(1));
    assign ignorable = (IGNORE_EN != 0) && (dataadr == IGNORE_ADR);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        count_nxt = count;
        cyc_nxt   = cyc;
        pass_nxt  = pass;
        fail_nxt  = fail;
        code_nxt  = fail_code;
        fidx_nxt  = fail_idx;
        fadr_nxt  = fail_adr;
        fdata_nxt = fail_data;
        case (state)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    // counts above DEPTH would walk ptr off the table
                    count_nxt = (cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_count;
                    ptr_nxt   = '0;
                    cyc_nxt   = '0;
                    pass_nxt  = 1'b0;
                    fail_nxt  = 1'b0;
                    code_nxt  = 2'd0;
                    fidx_nxt  = '0;
                    fadr_nxt  = '0;
                    fdata_nxt = '0;
                    if (cfg_count == '0) begin
                        state_nxt = FAIL;
                        fail_nxt  = 1'b1;
                        code_nxt  = CODE_EMPTY;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                cyc_nxt = cyc + TW'(1);
                if (memwrite && hit) begin
                    if (last) begin
                        state_nxt = PASS;
                        pass_nxt  = 1'b1;
                    end else begin
                        ptr_nxt = ptr + IW'(1);
                    end
                end else if (memwrite && !ignorable) begin
                    state_nxt = FAIL;
                    fail_nxt  = 1'b1;
                    code_nxt  = CODE_MISMATCH;
                    fidx_nxt  = ptr;
                    fadr_nxt  = dataadr;
                    fdata_nxt = writedata;
                end
                if (state_nxt == RUN && cyc == TW'(TIMEOUT - 1)) begin
                    state_nxt = FAIL;
                    fail_nxt  = 1'b1;
                    code_nxt  = CODE_TIMEOUT;
                    fidx_nxt  = ptr;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            count     <= '0;
            cyc       <= '0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
            fail_idx  <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            count     <= count_nxt;
            cyc       <= cyc_nxt;
            busy      <= busy_nxt;
            pass      <= pass_nxt;
            fail      <= fail_nxt;
            fail_code <= code_nxt;
            fail_idx  <= fidx_nxt;
            fail_adr  <= fadr_nxt;
            fail_data <= fdata_nxt;
        end
    end
endmodule

// File: tb/tb_memwrite_checker.sv
// Directed bench for memwrite_checker: expected outcomes are queued when a
// write sequence is driven and compared when the checker reports.
module tb_memwrite_checker;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_adr;
    logic [31:0] cfg_data;
    logic [3:0]  cfg_count;
    logic        start;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        busy, pass, fail;
    logic [1:0]  fail_code;
    logic [2:0]  fail_idx;
    logic [31:0] fail_adr;
    logic [31:0] fail_data;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic        p;
        logic        f;
        logic [1:0]  code;
        logic [2:0]  idx;
        logic [31:0] adr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    memwrite_checker #(.DEPTH(8), .AW(32), .DW(32), .TIMEOUT(20), .IGNORE_EN(1), .IGNORE_ADR(32'd80)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .cfg_count(cfg_count), .start(start),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_idx(fail_idx), .fail_adr(fail_adr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cfg(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = i; cfg_adr = a; cfg_data = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic arm(input logic [3:0] c);
        cfg_count = c; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick(1);
        memwrite = 1'b0;
    endtask

    task automatic exp_push(input logic p, input logic f, input logic [1:0] c,
                            input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.p = p; e.f = f; e.code = c; e.idx = i; e.adr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_mis++;
            $error("FAIL %s.sb: observed 0 queued expectations, expected at least 1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".pass"}, 64'(pass), 64'(e.p));
            check({tag, ".fail"}, 64'(fail), 64'(e.f));
            check({tag, ".code"}, 64'(fail_code), 64'(e.code));
            check({tag, ".idx"},  64'(fail_idx), 64'(e.idx));
            check({tag, ".adr"},  64'(fail_adr), 64'(e.adr));
            check({tag, ".data"}, 64'(fail_data), 64'(e.data));
        end
    endtask

    initial begin
        int waited;
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
        cfg_count = '0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        tick(2);
        exp_push(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        collect("reset");
        check("reset.busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick(1);

        // single entry, scratch write tolerated, then the real write
        cfg(3'd0, 32'd84, 32'd7);
        arm(4'd1);
        check("t1.busy_after_start", 64'(busy), 64'd1);
        wr(32'd80, 32'd5);
        check("t1.busy_after_ignore", 64'(busy), 64'd1);
        check("t1.pass_after_ignore", 64'(pass), 64'd0);
        exp_push(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        wr(32'd84, 32'd7);
        collect("t1");
        check("t1.busy_done", 64'(busy), 64'd0);

        // wrong address
        arm(4'd1);
        check("t2.pass_cleared", 64'(pass), 64'd0);
        exp_push(1'b0, 1'b1, 2'd1, 3'd0, 32'd88, 32'd7);
        wr(32'd88, 32'd7);
        collect("t2");

        // three entries in order with idle gaps
        cfg(3'd0, 32'd0, 32'd1);
        cfg(3'd1, 32'd4, 32'd2);
        cfg(3'd2, 32'd8, 32'd3);
        arm(4'd3);
        check("t3.fail_cleared", 64'(fail), 64'd0);
        wr(32'd0, 32'd1);
        tick(2);
        wr(32'd4, 32'd2);
        tick(1);
        check("t3.pass_early", 64'(pass), 64'd0);
        exp_push(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        wr(32'd8, 32'd3);
        collect("t3");

        // out-of-order second write
        arm(4'd3);
        wr(32'd0, 32'd1);
        exp_push(1'b0, 1'b1, 2'd1, 3'd1, 32'd8, 32'd3);
        wr(32'd8, 32'd3);
        collect("t3ooo");

        // timeout with no writes: fail lands 20 cycles after the start edge
        cfg(3'd0, 32'd84, 32'd7);
        arm(4'd1);
        waited = 0;
        exp_push(1'b0, 1'b1, 2'd2, 3'd0, 32'd0, 32'd0);
        while (!fail && !pass && waited < 40) begin
            tick(1);
            waited++;
        end
        check("t4.timeout_cycles", 64'(waited), 64'd20);
        collect("t4");

        // matching write on the last counted cycle wins over timeout
        arm(4'd1);
        tick(19);
        check("t4b.fail_before", 64'(fail), 64'd0);
        check("t4b.busy_before", 64'(busy), 64'd1);
        exp_push(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        wr(32'd84, 32'd7);
        collect("t4b");

        // empty table
        exp_push(1'b0, 1'b1, 2'd3, 3'd0, 32'd0, 32'd0);
        arm(4'd0);
        collect("t5");
        check("t5.busy", 64'(busy), 64'd0);

        // reset in the middle of a run
        arm(4'd1);
        wr(32'd80, 32'd5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_push(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        collect("t5rst");
        check("t5rst.busy", 64'(busy), 64'd0);

        // expected entry at the scratch address is matched, not ignored
        cfg(3'd0, 32'd80, 32'd5);
        arm(4'd1);
        exp_push(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        wr(32'd80, 32'd5);
        collect("t6prec");

        // table write and start during RUN are both ignored
        cfg(3'd0, 32'd84, 32'd7);
        cfg(3'd1, 32'd88, 32'd9);
        arm(4'd2);
        cfg(3'd0, 32'd100, 32'd1);
        wr(32'd84, 32'd7);
        check("t6.busy_mid", 64'(busy), 64'd1);
        arm(4'd1);
        check("t6.busy_after_restart", 64'(busy), 64'd1);
        exp_push(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        wr(32'd88, 32'd9);
        collect("t6");
        arm(4'd1);
        exp_push(1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        wr(32'd84, 32'd7);
        collect("t6keep");

        check("sb.drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
